// File: rtl/pacman_pkg.sv
// Shared direction/key codes, grid geometry and helpers for the Pac-Man movement engine.
package pacman_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [7:0] KEY_UP    = 8'hf7;
   localparam logic [7:0] KEY_LEFT  = 8'he1;
   localparam logic [7:0] KEY_DOWN  = 8'hf3;
   localparam logic [7:0] KEY_RIGHT = 8'he4;

   localparam int CELL_SHIFT = 4;
   localparam int GRID_BITS  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_W,
      ST_RD_W,
      ST_REQ_C,
      ST_RD_C,
      ST_STEP
   } motion_state_t;

   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d ^ 2'd2;
   endfunction

   // Tile address {row, col} of the cell next to the one containing (x, y); wraps mod 32.
   function automatic logic [2*GRID_BITS-1:0] neighbour_addr(input logic [8:0] x,
                                                             input logic [8:0] y,
                                                             input logic [1:0] d);
      logic [GRID_BITS-1:0] row;
      logic [GRID_BITS-1:0] col;
      row = y[CELL_SHIFT +: GRID_BITS];
      col = x[CELL_SHIFT +: GRID_BITS];
      case (d)
         DIR_UP:   row = row - 5'd1;
         DIR_LEFT: col = col - 5'd1;
         DIR_DOWN: row = row + 5'd1;
         default:  col = col + 5'd1;
      endcase
      return {row, col};
   endfunction

endpackage

// File: rtl/pacman_key_decoder.sv
// Keycode acknowledge handshake and the wanted-direction register.
// One-cycle strobe per accepted code; the input is ignored while the strobe is high.
module pacman_key_decoder
   import pacman_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_keycode,
   output logic       o_keystrobe,
   output logic [1:0] o_want_dir
);

   logic       r_keystrobe;
   logic [1:0] r_want_dir;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_keystrobe <= 1'b0;
         r_want_dir  <= DIR_LEFT;
      end else if (i_keycode[7] && !r_keystrobe) begin
         r_keystrobe <= 1'b1;
         // Unknown codes are still acknowledged but leave the wanted direction alone.
         case (i_keycode)
            KEY_UP:    r_want_dir <= DIR_UP;
            KEY_LEFT:  r_want_dir <= DIR_LEFT;
            KEY_DOWN:  r_want_dir <= DIR_DOWN;
            KEY_RIGHT: r_want_dir <= DIR_RIGHT;
            default:   r_want_dir <= r_want_dir;
         endcase
      end else begin
         r_keystrobe <= 1'b0;
      end
   end

   assign o_keystrobe = r_keystrobe;
   assign o_want_dir  = r_want_dir;

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pac-Man movement: key decode, tile-RAM wall lookup and position update on each vsync rise.
// Aligned frames take 3 cycles plus grant wait, mid-cell frames 1 cycle; ticks arriving while busy are dropped.
module pacman_motion_ctrl
   import pacman_pkg::*;
#(
   parameter logic [8:0] START_X = 9'd16,
   parameter logic [8:0] START_Y = 9'd16,
   parameter int         SPEED   = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vsync,
   input  logic [7:0] i_keycode,
   output logic       o_keystrobe,
   output logic       o_tile_req,
   input  logic       i_tile_grant,
   output logic [9:0] o_tile_addr,
   input  logic [7:0] i_tile_rdata,
   output logic [8:0] o_pac_x,
   output logic [8:0] o_pac_y,
   output logic [1:0] o_direction,
   output logic       o_moving
);

   localparam logic [8:0] STEP_PX = 9'(SPEED);

   motion_state_t r_state, w_state;
   logic          r_vsync_q;
   logic [8:0]    r_pac_x, w_pac_x;
   logic [8:0]    r_pac_y, w_pac_y;
   logic [1:0]    r_dir, w_dir;
   logic          r_moving, w_moving;
   logic          r_tile_req, w_tile_req;
   logic [9:0]    r_tile_addr, w_tile_addr;

   logic [1:0]    w_want_dir;
   logic          w_tick;
   logic          w_aligned;
   logic          w_wall;
   logic          w_unused_rdata;

   pacman_key_decoder u_key_decoder (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_keycode   (i_keycode),
      .o_keystrobe (o_keystrobe),
      .o_want_dir  (w_want_dir)
   );

   assign w_tick         = i_vsync & ~r_vsync_q;
   assign w_aligned      = (r_pac_x[CELL_SHIFT-1:0] == '0) && (r_pac_y[CELL_SHIFT-1:0] == '0);
   assign w_wall         = |i_tile_rdata[1:0];
   assign w_unused_rdata = ^i_tile_rdata[7:2];

   always_comb begin
      w_state     = r_state;
      w_pac_x     = r_pac_x;
      w_pac_y     = r_pac_y;
      w_dir       = r_dir;
      w_moving    = r_moving;
      w_tile_req  = r_tile_req;
      w_tile_addr = r_tile_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               if (!w_aligned) begin
                  // Mid-cell only an about-face is allowed; turns wait for the next cell boundary.
                  if (w_want_dir == opposite(r_dir)) w_dir = w_want_dir;
                  w_state = ST_STEP;
               end else begin
                  w_tile_addr = neighbour_addr(r_pac_x, r_pac_y, w_want_dir);
                  w_tile_req  = 1'b1;
                  w_state     = ST_REQ_W;
               end
            end
         end
         ST_REQ_W, ST_REQ_C: begin
            if (i_tile_grant) begin
               w_tile_req = 1'b0;
               w_state    = (r_state == ST_REQ_W) ? ST_RD_W : ST_RD_C;
            end
         end
         ST_RD_W: begin
            if (!w_wall) begin
               w_dir   = w_want_dir;
               w_state = ST_STEP;
            end else if (w_want_dir == r_dir) begin
               w_moving = 1'b0;
               w_state  = ST_IDLE;
            end else begin
               // Wanted turn is blocked: fall back to continuing in the current direction.
               w_tile_addr = neighbour_addr(r_pac_x, r_pac_y, r_dir);
               w_tile_req  = 1'b1;
               w_state     = ST_REQ_C;
            end
         end
         ST_RD_C: begin
            if (!w_wall) begin
               w_state = ST_STEP;
            end else begin
               w_moving = 1'b0;
               w_state  = ST_IDLE;
            end
         end
         ST_STEP: begin
            case (r_dir)
               DIR_UP:   w_pac_y = r_pac_y - STEP_PX;
               DIR_LEFT: w_pac_x = r_pac_x - STEP_PX;
               DIR_DOWN: w_pac_y = r_pac_y + STEP_PX;
               default:  w_pac_x = r_pac_x + STEP_PX;
            endcase
            w_moving = 1'b1;
            w_state  = ST_IDLE;
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_vsync_q   <= 1'b0;
         r_pac_x     <= START_X;
         r_pac_y     <= START_Y;
         r_dir       <= DIR_LEFT;
         r_moving    <= 1'b0;
         r_tile_req  <= 1'b0;
         r_tile_addr <= '0;
      end else begin
         r_state     <= w_state;
         r_vsync_q   <= i_vsync;
         r_pac_x     <= w_pac_x;
         r_pac_y     <= w_pac_y;
         r_dir       <= w_dir;
         r_moving    <= w_moving;
         r_tile_req  <= w_tile_req;
         r_tile_addr <= w_tile_addr;
      end
   end

   assign o_tile_req  = r_tile_req;
   assign o_tile_addr = r_tile_addr;
   assign o_pac_x     = r_pac_x;
   assign o_pac_y     = r_pac_y;
   assign o_direction = r_dir;
   assign o_moving    = r_moving;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Directed bench for pacman_motion_ctrl with a synchronous tile-RAM model and hand-computed expectations.
module tb_pacman_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vsync = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       keystrobe;
   logic       tile_req;
   logic       tile_grant = 1'b0;
   logic [9:0] tile_addr;
   logic [7:0] tile_rdata = 8'h00;
   logic [8:0] pac_x;
   logic [8:0] pac_y;
   logic [1:0] direction;
   logic       moving;

   logic [7:0] mem [0:1023];
   int         n_cmp = 0;
   int         n_err = 0;
   int         req_cnt = 0;
   int         req_base;

   always #5 clk = ~clk;

   pacman_motion_ctrl #(.START_X(9'd16), .START_Y(9'd16), .SPEED(2)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_vsync      (vsync),
      .i_keycode    (keycode),
      .o_keystrobe  (keystrobe),
      .o_tile_req   (tile_req),
      .i_tile_grant (tile_grant),
      .o_tile_addr  (tile_addr),
      .i_tile_rdata (tile_rdata),
      .o_pac_x      (pac_x),
      .o_pac_y      (pac_y),
      .o_direction  (direction),
      .o_moving     (moving)
   );

   // Synchronous RAM: data for the granted address appears the cycle after the grant.
   always @(posedge clk) begin
      if (tile_grant) tile_rdata <= mem[tile_addr];
      if (tile_req) req_cnt <= req_cnt + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns one negedge after the clock edge that registers the tick.
   task automatic frame_tick();
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) vsync = 1'b0;
   endtask

   task automatic press(input logic [7:0] code);
      @(negedge clk) keycode = code;
      @(negedge clk) keycode = 8'h00;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      cycles(2);
      check("rst_pac_x", 16'(pac_x), 16'd16);
      check("rst_pac_y", 16'(pac_y), 16'd16);
      check("rst_dir", 16'(direction), 16'd1);
      check("rst_moving", 16'(moving), 16'd0);
      check("rst_keystrobe", 16'(keystrobe), 16'd0);
      check("rst_tile_req", 16'(tile_req), 16'd0);
      check("rst_tile_addr", 16'(tile_addr), 16'h000);
      check("rst_want", 16'(u_dut.w_want_dir), 16'd1);
      rst_n = 1'b1;

      // Reset asserted while a request is pending in REQ_W.
      frame_tick();
      check("reqw_req", 16'(tile_req), 16'd1);
      check("reqw_addr", 16'(tile_addr), 16'h020);
      cycles(2);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req", 16'(tile_req), 16'd0);
      check("midrst_addr", 16'(tile_addr), 16'h000);
      check("midrst_dir", 16'(direction), 16'd1);
      @(negedge clk) rst_n = 1'b1;
      cycles(3);
      check("postrst_req", 16'(tile_req), 16'd0);
      check("postrst_x", 16'(pac_x), 16'd16);
      check("postrst_y", 16'(pac_y), 16'd16);
      check("postrst_ks", 16'(keystrobe), 16'd0);

      // Key handshake: strobe lasts one cycle, unknown code acknowledged but ignored.
      @(negedge clk) keycode = 8'he4;
      @(negedge clk) check("key_ks_hi", 16'(keystrobe), 16'd1);
      @(negedge clk) check("key_ks_lo", 16'(keystrobe), 16'd0);
      keycode = 8'h00;
      @(negedge clk) check("key_ks_idle", 16'(keystrobe), 16'd0);
      check("key_want_right", 16'(u_dut.w_want_dir), 16'd3);
      keycode = 8'h95;
      @(negedge clk) check("badkey_ks_hi", 16'(keystrobe), 16'd1);
      keycode = 8'h00;
      @(negedge clk) check("badkey_ks_lo", 16'(keystrobe), 16'd0);
      check("badkey_want", 16'(u_dut.w_want_dir), 16'd3);

      // Free move right from (1,1): cell (1,2) is empty, grant tied high.
      tile_grant = 1'b1;
      frame_tick();
      check("free_addr", 16'(tile_addr), 16'h022);
      check("free_req", 16'(tile_req), 16'd1);
      cycles(2);
      check("free_dir", 16'(direction), 16'd3);
      check("free_x_hold", 16'(pac_x), 16'd16);
      cycles(1);
      check("free_x", 16'(pac_x), 16'd18);
      check("free_moving", 16'(moving), 16'd1);
      cycles(2);

      // Tick and left key in the same cycle: this frame still moves right.
      @(negedge clk) begin vsync = 1'b1; keycode = 8'he1; end
      @(negedge clk) begin vsync = 1'b0; keycode = 8'h00; end
      check("same_ks", 16'(keystrobe), 16'd1);
      cycles(1);
      check("same_x", 16'(pac_x), 16'd20);
      check("same_dir", 16'(direction), 16'd3);
      cycles(2);

      // Mid-cell reversal without any tile request.
      req_base = req_cnt;
      frame_tick();
      check("rev_dir", 16'(direction), 16'd1);
      cycles(1);
      check("rev_x", 16'(pac_x), 16'd18);
      cycles(2);
      frame_tick();
      cycles(1);
      check("rev_x2", 16'(pac_x), 16'd16);
      check("rev_noreq", 16'(req_cnt - req_base), 16'd0);
      cycles(2);

      // Wall stop: left neighbour (1,0) and up neighbour (0,1) are walls.
      mem[10'h020] = 8'h01;
      mem[10'h001] = 8'h02;
      req_base = req_cnt;
      frame_tick();
      check("wall_addr", 16'(tile_addr), 16'h020);
      cycles(5);
      check("wall_reqs", 16'(req_cnt - req_base), 16'd1);
      check("wall_x", 16'(pac_x), 16'd16);
      check("wall_moving", 16'(moving), 16'd0);

      // Want up (wall), then fall back to current direction left (wall): stop after two reads.
      press(8'hf7);
      req_base = req_cnt;
      frame_tick();
      check("dbl_addr_w", 16'(tile_addr), 16'h001);
      cycles(2);
      check("dbl_addr_c", 16'(tile_addr), 16'h020);
      check("dbl_req_c", 16'(tile_req), 16'd1);
      cycles(4);
      check("dbl_reqs", 16'(req_cnt - req_base), 16'd2);
      check("dbl_dir", 16'(direction), 16'd1);
      check("dbl_x", 16'(pac_x), 16'd16);

      // Up still blocked, left now free: continue left.
      mem[10'h020] = 8'h00;
      frame_tick();
      cycles(6);
      check("fallback_x", 16'(pac_x), 16'd14);
      check("fallback_dir", 16'(direction), 16'd1);
      check("fallback_moving", 16'(moving), 16'd1);

      // Walk left mid-cell down to the column-0 boundary.
      for (int i = 0; i < 7; i++) begin
         frame_tick();
         cycles(2);
      end
      check("walk_x", 16'(pac_x), 16'd0);
      check("walk_y", 16'(pac_y), 16'd16);

      // Tunnel wrap to column 31 with a 5-cycle grant delay.
      press(8'he1);
      tile_grant = 1'b0;
      frame_tick();
      for (int i = 0; i < 5; i++) begin
         check("wrap_addr_hold", 16'(tile_addr), 16'h03F);
         check("wrap_req_hold", 16'(tile_req), 16'd1);
         if (i < 4) @(negedge clk);
      end
      tile_grant = 1'b1;
      cycles(3);
      check("wrap_x", 16'(pac_x), 16'd510);
      check("wrap_y", 16'(pac_y), 16'd16);
      check("wrap_dir", 16'(direction), 16'd1);
      check("wrap_moving", 16'(moving), 16'd1);
      check("wrap_req_done", 16'(tile_req), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
